// File: rtl/piecewise_max_pipe.sv
// piecewise_max_pipe: y = max_i(((slope[i]*x) >>> FBITS) + offset[i]) in Q(WID,FBITS),
// with a writable coefficient bank, a 3-stage stallable pipeline and a sticky overflow flag.
module piecewise_max_pipe #(
  parameter int WID      = 16,
  parameter int FBITS    = 8,
  parameter int NSEG     = 4,
  parameter int SATURATE = 0,
  parameter int IDXW     = $clog2(NSEG)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [IDXW-1:0]       cfg_addr,
  input  logic signed [WID-1:0] cfg_slope,
  input  logic signed [WID-1:0] cfg_off,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic signed [WID-1:0] in_x,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic signed [WID-1:0] out_y,
  output logic [IDXW-1:0]       out_idx,
  output logic                  ovf,
  input  logic                  clr_ovf
);

  localparam int PW = 2 * WID;
  localparam int FW = PW + 1;
  localparam logic signed [WID-1:0] Y_MAX = {1'b0, {(WID-1){1'b1}}};
  localparam logic signed [WID-1:0] Y_MIN = {1'b1, {(WID-1){1'b0}}};

  logic                  stall;
  logic                  adv;

  logic signed [WID-1:0] slope_q [NSEG];
  logic signed [WID-1:0] slope_d [NSEG];
  logic signed [WID-1:0] off_q   [NSEG];
  logic signed [WID-1:0] off_d   [NSEG];

  logic                  s1_valid_q, s1_valid_d;
  logic signed [WID-1:0] s1_x_q, s1_x_d;

  logic signed [PW-1:0]  prod    [NSEG];
  logic signed [FW-1:0]  full    [NSEG];
  logic signed [WID-1:0] seg_res [NSEG];
  logic [NSEG-1:0]       oor;

  logic                  s2_valid_q, s2_valid_d;
  logic signed [WID-1:0] s2_res_q [NSEG];
  logic signed [WID-1:0] s2_res_d [NSEG];

  logic signed [WID-1:0] best_y;
  logic [IDXW-1:0]       best_idx;

  logic                  out_valid_q, out_valid_d;
  logic signed [WID-1:0] out_y_q, out_y_d;
  logic [IDXW-1:0]       out_idx_q, out_idx_d;
  logic                  ovf_q, ovf_d;

  // The whole pipeline freezes while a finished result waits for the consumer.
  assign stall    = out_valid_q && !out_ready;
  assign adv      = !stall;
  assign in_ready = !stall;

  always_comb begin
    slope_d = slope_q;
    off_d   = off_q;
    for (int i = 0; i < NSEG; i++) begin
      if (cfg_we && (cfg_addr == IDXW'(i))) begin
        slope_d[i] = cfg_slope;
        off_d[i]   = cfg_off;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NSEG; i++) begin
        slope_q[i] <= '0;
        off_q[i]   <= '0;
      end
    end else begin
      slope_q <= slope_d;
      off_q   <= off_d;
    end
  end

  always_comb begin
    s1_valid_d = adv ? in_valid : s1_valid_q;
    s1_x_d     = (adv && in_valid) ? in_x : s1_x_q;
  end

  // Full-precision segment results; the range test looks at every bit above the WID-bit window.
  always_comb begin
    for (int i = 0; i < NSEG; i++) begin
      prod[i] = PW'(slope_q[i]) * PW'(s1_x_q);
      full[i] = FW'(prod[i] >>> FBITS) + FW'(off_q[i]);
      oor[i]  = !((&full[i][FW-1:WID-1]) || !(|full[i][FW-1:WID-1]));
      if (oor[i] && (SATURATE != 0)) begin
        seg_res[i] = full[i][FW-1] ? Y_MIN : Y_MAX;
      end else begin
        seg_res[i] = full[i][WID-1:0];
      end
    end
  end

  always_comb begin
    s2_valid_d = adv ? s1_valid_q : s2_valid_q;
    s2_res_d   = s2_res_q;
    if (adv && s1_valid_q) begin
      s2_res_d = seg_res;
    end
  end

  // Overflow is only raised when a sample actually moves into S2, so a held sample cannot re-set it.
  always_comb begin
    ovf_d = ovf_q && !clr_ovf;
    if (adv && s1_valid_q && (|oor)) begin
      ovf_d = 1'b1;
    end
  end

  always_comb begin
    best_y   = s2_res_q[0];
    best_idx = '0;
    for (int i = 1; i < NSEG; i++) begin
      if (s2_res_q[i] > best_y) begin
        best_y   = s2_res_q[i];
        best_idx = IDXW'(i);
      end
    end
  end

  always_comb begin
    out_valid_d = adv ? s2_valid_q : out_valid_q;
    out_y_d     = out_y_q;
    out_idx_d   = out_idx_q;
    if (adv && s2_valid_q) begin
      out_y_d   = best_y;
      out_idx_d = best_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s2_valid_q  <= 1'b0;
      for (int i = 0; i < NSEG; i++) begin
        s2_res_q[i] <= '0;
      end
      out_valid_q <= 1'b0;
      out_y_q     <= '0;
      out_idx_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s2_valid_q  <= s2_valid_d;
      s2_res_q    <= s2_res_d;
      out_valid_q <= out_valid_d;
      out_y_q     <= out_y_d;
      out_idx_q   <= out_idx_d;
      ovf_q       <= ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_y     = out_y_q;
  assign out_idx   = out_idx_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_piecewise_max_pipe.sv
// tb_piecewise_max_pipe: directed and randomized checks of piecewise_max_pipe (wrap and saturate
// instances side by side) against an arithmetic reference model of the max-of-segments function.
module tb_piecewise_max_pipe;

  localparam int WID   = 16;
  localparam int FBITS = 8;
  localparam int NSEG  = 4;
  localparam int IDXW  = 2;

  typedef struct {
    int y;
    int idx;
    int ys;
    int idxs;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  cfg_we, clr_ovf, in_valid, out_ready;
  logic [IDXW-1:0]       cfg_addr;
  logic signed [WID-1:0] cfg_slope, cfg_off, in_x;
  logic                  in_ready, out_valid, ovf;
  logic signed [WID-1:0] out_y;
  logic [IDXW-1:0]       out_idx;
  logic                  in_ready_s, out_valid_s, ovf_s;
  logic signed [WID-1:0] out_y_s;
  logic [IDXW-1:0]       out_idx_s;

  int   assert_cnt = 0;
  int   fail_cnt = 0;
  int   m_slope [NSEG];
  int   m_off   [NSEG];
  bit   m_ovf;
  exp_t exp_q [$];
  int   stim_q [$];
  int   bp_x [6] = '{-768, 512, 0, 300, -5, 1000};
  bit   vrec [4];
  int   y, idx, ys, idxs, edges, n, got, cyc, yhold;
  int   res [2];

  always #5 clk = ~clk;

  piecewise_max_pipe #(.WID(WID), .FBITS(FBITS), .NSEG(NSEG), .SATURATE(0)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_slope(cfg_slope),
    .cfg_off(cfg_off), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_idx(out_idx),
    .ovf(ovf), .clr_ovf(clr_ovf)
  );

  piecewise_max_pipe #(.WID(WID), .FBITS(FBITS), .NSEG(NSEG), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_slope(cfg_slope),
    .cfg_off(cfg_off), .in_valid(in_valid), .in_ready(in_ready_s), .in_x(in_x),
    .out_valid(out_valid_s), .out_ready(out_ready), .out_y(out_y_s), .out_idx(out_idx_s),
    .ovf(ovf_s), .clr_ovf(clr_ovf)
  );

  // Reference: exact integer product, floor division by 2^FBITS, then wrap or clamp.
  function automatic exp_t model(int x);
    exp_t   e;
    longint d, p, q, f, w, s, best_w, best_s;
    d = longint'(1) << FBITS;
    best_w = 0;
    best_s = 0;
    e = '{0, 0, 0, 0};
    for (int i = 0; i < NSEG; i++) begin
      p = longint'(m_slope[i]) * longint'(x);
      q = p / d;
      if ((p % d) != 0 && p < 0) q = q - 1;
      f = q + longint'(m_off[i]);
      w = ((f % 65536) + 65536) % 65536;
      if (w > 32767) w = w - 65536;
      s = (f > 32767) ? 32767 : ((f < -32768) ? -32768 : f);
      if (f > 32767 || f < -32768) m_ovf = 1'b1;
      if (i == 0 || w > best_w) begin
        best_w = w;
        e.idx  = i;
      end
      if (i == 0 || s > best_s) begin
        best_s = s;
        e.idxs = i;
      end
    end
    e.y  = int'(best_w);
    e.ys = int'(best_s);
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                             input logic signed [31:0] expected);
    assert_cnt++;
    assert (observed === expected) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic writeCoef(input int a, input int s, input int o);
    cfg_we    = 1'b1;
    cfg_addr  = IDXW'(a);
    cfg_slope = WID'(s);
    cfg_off   = WID'(o);
    cycle();
    cfg_we    = 1'b0;
    m_slope[a] = s;
    m_off[a]   = o;
  endtask

  task automatic writeAbs();
    writeCoef(0, 256, 0);
    writeCoef(1, -256, 0);
    writeCoef(2, 0, -32768);
    writeCoef(3, 0, -32768);
  endtask

  // One isolated sample; edges counts the accepting edge plus those until out_valid rises.
  task automatic runSample(input int x, output int oy, output int oidx, output int oys,
                           output int oidxs, output int oedges);
    in_valid  = 1'b1;
    in_x      = WID'(x);
    out_ready = 1'b1;
    #2;
    checkOutput("in_ready_before_send", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    oedges = 1;
    while (!out_valid && oedges < 10) begin
      cycle();
      oedges++;
    end
    if (!out_valid) checkOutput("result_timeout", out_valid, 1);
    oy    = $signed(out_y);
    oidx  = out_idx;
    oys   = $signed(out_y_s);
    oidxs = out_idx_s;
    cycle();
  endtask

  // Streams stim_q with random valid/ready and scores every consumed result in order.
  task automatic applyStimulus(input int ready_pct, input int valid_pct, input int max_cycles);
    int   c;
    int   xv;
    exp_t e;
    c = 0;
    while ((stim_q.size() > 0 || exp_q.size() > 0) && c < max_cycles) begin
      in_valid = (stim_q.size() > 0) && (int'($urandom_range(99)) < valid_pct);
      if (in_valid) in_x = WID'(stim_q[0]);
      else          in_x = WID'($urandom);
      out_ready = int'($urandom_range(99)) < ready_pct;
      #2;
      if (in_valid && in_ready) begin
        xv = stim_q.pop_front();
        exp_q.push_back(model(xv));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          checkOutput("stream_y", $signed(out_y), e.y);
          checkOutput("stream_idx", out_idx, e.idx);
          checkOutput("stream_y_sat", $signed(out_y_s), e.ys);
          checkOutput("stream_idx_sat", out_idx_s, e.idxs);
        end
      end
      @(posedge clk);
      #1;
      c++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("stream_pending", stim_q.size() + exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    cfg_we = 0; cfg_addr = '0; cfg_slope = '0; cfg_off = '0;
    in_valid = 0; in_x = '0; out_ready = 1; clr_ovf = 0;
    for (int i = 0; i < NSEG; i++) begin
      m_slope[i] = 0;
      m_off[i]   = 0;
    end
    m_ovf = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #2;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_y", $signed(out_y), 0);
    checkOutput("reset_out_idx", out_idx, 0);
    checkOutput("reset_ovf", ovf, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_in_ready_sat", in_ready_s, 1);

    $display("[TB] absolute value");
    writeAbs();
    runSample(-768, y, idx, ys, idxs, edges);
    checkOutput("abs_neg_latency", edges, 3);
    checkOutput("abs_neg_y", y, 768);
    checkOutput("abs_neg_idx", idx, 1);
    checkOutput("abs_neg_y_sat", ys, 768);
    runSample(512, y, idx, ys, idxs, edges);
    checkOutput("abs_pos_y", y, 512);
    checkOutput("abs_pos_idx", idx, 0);
    runSample(0, y, idx, ys, idxs, edges);
    checkOutput("abs_zero_y", y, 0);
    checkOutput("abs_zero_tie_idx", idx, 0);

    $display("[TB] floor rounding");
    writeCoef(0, 1, 0);
    writeCoef(1, 0, -32768);
    runSample(-1, y, idx, ys, idxs, edges);
    checkOutput("floor_m1_y", y, -1);
    runSample(255, y, idx, ys, idxs, edges);
    checkOutput("floor_255_y", y, 0);
    checkOutput("floor_no_ovf", ovf, 0);

    $display("[TB] overflow");
    writeCoef(0, 32767, 0);
    runSample(32767, y, idx, ys, idxs, edges);
    checkOutput("ovf_wrap_y", y, -256);
    checkOutput("ovf_wrap_idx", idx, 0);
    checkOutput("ovf_sat_y", ys, 32767);
    checkOutput("ovf_flag", ovf, 1);
    checkOutput("ovf_flag_sat", ovf_s, 1);
    clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    #2;
    checkOutput("ovf_cleared", ovf, 0);
    checkOutput("ovf_cleared_sat", ovf_s, 0);

    $display("[TB] overflow clear while stalled");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_x      = WID'(32767);
    repeat (3) begin
      exp_q.push_back(model(32767));
      cycle();
    end
    in_valid = 1'b0;
    #2;
    checkOutput("stall_ovf_set", ovf, 1);
    checkOutput("stall_in_ready", in_ready, 0);
    clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    cycle();
    checkOutput("stall_ovf_not_reset", ovf, 0);
    applyStimulus(100, 100, 50);

    $display("[TB] backpressure");
    writeAbs();
    out_ready = 1'b0;
    n = 0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1;
      in_x     = WID'(bp_x[n]);
      #2;
      vrec[c] = out_valid;
      if (in_ready) begin
        exp_q.push_back(model(bp_x[n]));
        n++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("bp_accepted", n, 3);
    checkOutput("bp_valid_edge2", vrec[1], 0);
    checkOutput("bp_valid_edge3_pre", vrec[2], 0);
    checkOutput("bp_valid_after3", vrec[3], 1);
    checkOutput("bp_in_ready_low", in_ready, 0);
    yhold = $signed(out_y);
    repeat (2) cycle();
    checkOutput("bp_hold_y", $signed(out_y), yhold);
    checkOutput("bp_hold_valid", out_valid, 1);
    checkOutput("bp_first_y", $signed(out_y), 768);
    for (int i = 3; i < 6; i++) stim_q.push_back(bp_x[i]);
    applyStimulus(100, 100, 60);
    checkOutput("bp_drained_valid", out_valid, 0);

    $display("[TB] coefficient update mid-stream");
    in_valid  = 1'b1;
    in_x      = WID'(100);
    out_ready = 1'b1;
    cycle();
    cfg_we    = 1'b1;
    cfg_addr  = '0;
    cfg_slope = WID'(512);
    cfg_off   = '0;
    cycle();
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    m_slope[0] = 512;
    got = 0;
    cyc = 0;
    while (got < 2 && cyc < 10) begin
      if (out_valid) begin
        res[got] = $signed(out_y);
        got++;
      end
      cycle();
      cyc++;
    end
    checkOutput("cfg_mid_count", got, 2);
    checkOutput("cfg_mid_old_coef", res[0], 100);
    checkOutput("cfg_mid_new_coef", res[1], 200);

    $display("[TB] reset mid-stream");
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_x      = WID'(50);
    repeat (3) cycle();
    in_valid = 1'b0;
    checkOutput("rst_pre_valid", out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_async_valid", out_valid, 0);
    checkOutput("rst_async_y", $signed(out_y), 0);
    checkOutput("rst_async_ovf", ovf, 0);
    checkOutput("rst_async_valid_sat", out_valid_s, 0);
    cycle();
    rst_n = 1'b1;
    for (int i = 0; i < NSEG; i++) begin
      m_slope[i] = 0;
      m_off[i]   = 0;
    end
    exp_q.delete();
    runSample(100, y, idx, ys, idxs, edges);
    checkOutput("rst_after_y", y, 0);
    checkOutput("rst_after_idx", idx, 0);
    checkOutput("rst_after_y_sat", ys, 0);

    $display("[TB] randomized stream");
    for (int i = 0; i < NSEG; i++) begin
      if ($urandom_range(3) == 0) begin
        writeCoef(i, int'($signed(WID'($urandom))), int'($signed(WID'($urandom))));
      end else begin
        writeCoef(i, int'($urandom_range(1024)) - 512, int'($urandom_range(8192)) - 4096);
      end
    end
    clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    m_ovf = 1'b0;
    for (int i = 0; i < 200; i++) stim_q.push_back(int'($signed(WID'($urandom))));
    applyStimulus(70, 70, 3000);
    cycle();
    checkOutput("rand_ovf", ovf, m_ovf);
    checkOutput("rand_ovf_sat", ovf_s, m_ovf);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
